chia_xung: RTL and testbench

CHIA_XUNG -- requirements
Module: chia_xung

---
 rtl/chia_xung.sv | 85 ++++++++
 tb/tb_chia_xung.sv | 137 +++++++++++++
 2 files changed

// File: rtl/chia_xung.sv
// chia_xung: integer clock divider.
// clko has a period of exactly DIV clki cycles. Its first rising edge falls on
// the DIV-th clki rising edge after reset release.
// Optional macro CHIA_XUNG_ODD50_EN: for odd DIV >= 3, a falling-edge register
// stretches the high phase by half a clki cycle, which gives exact 50% duty.
module chia_xung #(
  parameter int DIV = 10
) (
  input  logic clki,
  input  logic rst,
  output logic clko
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef CHIA_XUNG_ODD50_EN
  localparam bit ODD50 = (DIV >= 3) && ((DIV % 2) == 1);
`else
  localparam bit ODD50 = 1'b0;
`endif

  // High time in clki cycles, as seen by the rising-edge register alone
  localparam int HI = ODD50 ? (DIV - 1) / 2 : (DIV + 1) / 2;

  generate
    if (DIV < 1 || DIV > 65535) begin : g_bad_div
      $error("chia_xung: DIV must be in 1..65535");
    end

    if (DIV == 1) begin : g_bypass
      // Divide-by-one is a gated pass-through; reset holds the output low
      assign clko = clki & ~rst;
    end else begin : g_div
      localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
      localparam logic [CW-1:0] HI_M1 = CW'(HI - 1);

      logic [CW-1:0] cnt;
      logic          clko_r;

      // Cycle counter, wraps after DIV-1
      always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      // Output register: set on wrap, cleared once HI cycles have elapsed
      always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
          clko_r <= 1'b0;
        end else if (cnt == LAST) begin
          clko_r <= 1'b1;
        end else if (cnt == HI_M1) begin
          clko_r <= 1'b0;
        end
      end

`ifdef CHIA_XUNG_ODD50_EN
      if (ODD50) begin : g_odd50
        logic clko_n;

        // Half-cycle extension: delays the fall to the next clki falling edge
        always_ff @(negedge clki or posedge rst) begin
          if (rst) begin
            clko_n <= 1'b0;
          end else begin
            clko_n <= clko_r;
          end
        end

        assign clko = clko_r | clko_n;
      end else begin : g_plain
        assign clko = clko_r;
      end
`else
      assign clko = clko_r;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_chia_xung.sv
// tb_chia_xung: checks four divider instances (DIV = 10, 2, 5, 1) against a
// timing model. The model counts half clki periods since reset release.
// Directed reset scenarios are followed by randomized reset and run segments.
module tb_chia_xung;

  logic clki = 1'b0;
  logic rst  = 1'b1;
  logic clko10, clko2, clko5, clko1;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // clki rising edges since last reset release

`ifdef CHIA_XUNG_ODD50_EN
  localparam int HH5 = 5;   // DIV=5 high time in half periods (50 ns)
`else
  localparam int HH5 = 6;   // DIV=5 high time in half periods (60 ns)
`endif

  chia_xung #(.DIV(10)) u_div10 (.clki(clki), .rst(rst), .clko(clko10));
  chia_xung #(.DIV(2))  u_div2  (.clki(clki), .rst(rst), .clko(clko2));
  chia_xung #(.DIV(5))  u_div5  (.clki(clki), .rst(rst), .clko(clko5));
  chia_xung #(.DIV(1))  u_div1  (.clki(clki), .rst(rst), .clko(clko1));

  // 20 ns clki period
  always #10 clki = ~clki;

  // Expected output h half periods after release.
  // Rising edge number k sits at h = 2k, and its following falling edge at h = 2k+1.
  // For DIV >= 2 the first rise is at rising edge DIV, which is h = 2*DIV.
  function automatic logic model(int div, int high_halves, int h);
    if (div == 1) return ((h % 2) == 0);
    if (h < 2 * div) return 1'b0;
    return (((h - 2 * div) % (2 * div)) < high_halves);
  endfunction

  task automatic check(string tag, logic observed, logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, observed, expected);
    end
  endtask

  task automatic check_all(int h);
    check("div10", clko10, model(10, 10, h));
    check("div2",  clko2,  model(2,  2,  h));
    check("div5",  clko5,  model(5,  HH5, h));
    check("div1",  clko1,  model(1,  0,  h));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_div10"}, clko10, 1'b0);
    check({tag, "_div2"},  clko2,  1'b0);
    check({tag, "_div5"},  clko5,  1'b0);
    check({tag, "_div1"},  clko1,  1'b0);
  endtask

  // Run n clki cycles, sampling 1 ns after each rising and falling edge
  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clki); #1;
      k++;
      check_all(2 * k);
      @(negedge clki); #1;
      check_all(2 * k + 1);
    end
  endtask

  // Hold reset for n cycles, expecting all outputs low at every edge
  task automatic hold_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clki); #1;
      check_zero("rst_hold_rise");
      @(negedge clki); #1;
      check_zero("rst_hold_fall");
    end
  endtask

  initial begin
    // Reset from 0 to 100 ns. Outputs must be low, including the DIV=1 output while clki is high.
    #5;
    check_zero("reset_state");
    #10;
    check_zero("reset_state_clk_high");
    #85;
    rst = 1'b0;
    k   = 0;

    // First rise at the 10th rising edge for DIV=10, then two full periods
    run(30);

    // Mid-period reset while the DIV=10 output is high
    k = 0;
    rst = 1'b1;
    #1;
    check_zero("boot2");
    @(negedge clki); #1;
    rst = 1'b0;
    run(12);
    check("mid_pre_high", clko10, 1'b1);
    #4;
    rst = 1'b1;
    #1;
    check_zero("mid_abort");
    #14;
    rst = 1'b0;
    k = 0;
    run(25);

    // Randomized reset pulses and run lengths
    for (int seg = 0; seg < 8; seg++) begin
      @(posedge clki);
      #($urandom_range(2, 8));
      rst = 1'b1;
      #1;
      check_zero("rand_abort");
      hold_reset($urandom_range(1, 3));
      @(negedge clki);
      #($urandom_range(1, 8));
      rst = 1'b0;
      k = 0;
      run($urandom_range(3, 45));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound on total simulation time
  initial begin
    #2000000;
    $display("FAIL timeout t=%0t observed=running expected=finished", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
